// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - multi-channel valid/ready memory request/response bundle
interface data_mem_responder_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency multi-channel memory responder over a word array
module data_mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   mem_if
);
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_mem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELAY} state_e;

    state_e                                 state_q [NUM_CHANNELS];
    state_e                                 state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][3:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0]                op_write_q, op_write_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
    logic [NUM_CHANNELS-1:0]                read_ready_q, read_ready_d;
    logic [NUM_CHANNELS-1:0]                write_ready_q, write_ready_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;
    logic [NUM_CHANNELS-1:0]                mem_we;

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_write_d    = op_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_ready_d  = read_ready_q;
        write_ready_d = write_ready_q;
        read_data_d   = read_data_q;
        mem_we        = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                S_IDLE: begin
                    if (mem_if.mem_read_valid[ch]) begin
                        addr_d[ch]     = mem_if.mem_read_address[ch];
                        op_write_d[ch] = 1'b0;
                        cnt_d[ch]      = CNT_INIT;
                        state_d[ch]    = S_WAIT;
                    end else if (mem_if.mem_write_valid[ch]) begin
                        addr_d[ch]     = mem_if.mem_write_address[ch];
                        wdata_d[ch]    = mem_if.mem_write_data[ch];
                        op_write_d[ch] = 1'b1;
                        cnt_d[ch]      = CNT_INIT;
                        state_d[ch]    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q[ch] != 4'd0) begin
                        cnt_d[ch] = cnt_q[ch] - 4'd1;
                    end else begin
                        // Reads sample the array before this edge's writes land, so same-edge reads see old data
                        if (op_write_q[ch]) begin
                            mem_we[ch]        = 1'b1;
                            write_ready_d[ch] = 1'b1;
                        end else begin
                            read_data_d[ch]  = mem_q[addr_q[ch]];
                            read_ready_d[ch] = 1'b1;
                        end
                        state_d[ch] = S_RELAY;
                    end
                end
                S_RELAY: begin
                    if (!(op_write_q[ch] ? mem_if.mem_write_valid[ch] : mem_if.mem_read_valid[ch])) begin
                        read_ready_d[ch]  = 1'b0;
                        write_ready_d[ch] = 1'b0;
                        state_d[ch]       = S_IDLE;
                    end
                end
                default: state_d[ch] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= S_IDLE;
            end
            cnt_q         <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_write_q    <= op_write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
        end
    end

    // Descending order makes the lowest channel the last assignment, so it wins address collisions
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
                if (mem_we[ch]) begin
                    mem_q[addr_q[ch]] <= wdata_q[ch];
                end
            end
        end
    end

    assign mem_if.mem_read_ready  = read_ready_q;
    assign mem_if.mem_write_ready = write_ready_q;
    assign mem_if.mem_read_data   = read_data_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [DB-1:0] model [2**AB];

    data_mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus ();

    data_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input int ch, input logic rv, input logic wv,
                         input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.mem_read_valid[ch]    = rv;
        bus.mem_write_valid[ch]   = wv;
        bus.mem_read_address[ch]  = a;
        bus.mem_write_address[ch] = a;
        bus.mem_write_data[ch]    = d;
    endtask

    // Returns rising edges from the capture edge until any masked channel shows ready
    task automatic wait_ready(input logic [NC-1:0] mask, output int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((bus.mem_read_ready | bus.mem_write_ready) & mask) == '0) && n < 50);
        lat = n - 1;
    endtask

    task automatic release_all(input logic [NC-1:0] mask);
        @(negedge clk);
        for (int ch = 0; ch < NC; ch++) if (mask[ch]) drive(ch, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int ch = 0; ch < NC; ch++) drive(ch, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_read_ready !== '0) begin failures++; $display("FAIL reset_read_ready got=%h exp=0", bus.mem_read_ready); end
        checks++; if (bus.mem_write_ready !== '0) begin failures++; $display("FAIL reset_write_ready got=%h exp=0", bus.mem_write_ready); end
        checks++; if (bus.mem_read_data !== '0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", bus.mem_read_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic init_mem();
        int lat;
        logic [DB-1:0] d;
        for (int k = 0; k < (2**AB) / NC; k++) begin
            for (int ch = 0; ch < NC; ch++) begin
                d = DB'($urandom);
                drive(ch, 1'b0, 1'b1, AB'(k * NC + ch), d);
                model[k * NC + ch] = d;
            end
            wait_ready('1, lat);
            release_all('1);
        end
    endtask

    task automatic test_write_basic();
        int lat;
        drive(0, 1'b0, 1'b1, 8'h10, 8'hA5);
        wait_ready(4'b0001, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_write_ready[0] !== 1'b1) begin failures++; $display("FAIL wr_hold got=%b exp=1", bus.mem_write_ready[0]); end
        drive(0, 1'b0, 1'b0, '0, '0);
        checks++; if (bus.mem_write_ready[0] !== 1'b1) begin failures++; $display("FAIL wr_before_fall got=%b exp=1", bus.mem_write_ready[0]); end
        @(negedge clk);
        checks++; if (bus.mem_write_ready[0] !== 1'b0) begin failures++; $display("FAIL wr_fall got=%b exp=0", bus.mem_write_ready[0]); end
        model[8'h10] = 8'hA5;
    endtask

    task automatic test_read_basic();
        int lat;
        drive(1, 1'b1, 1'b0, 8'h10, '0);
        wait_ready(4'b0010, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (bus.mem_read_data[1] !== model[8'h10]) begin failures++; $display("FAIL rd_data got=%h exp=%h", bus.mem_read_data[1], model[8'h10]); end
        drive(1, 1'b1, 1'b0, 8'h77, '0);
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_read_ready[1] !== 1'b1 || bus.mem_read_data[1] !== 8'hA5) begin
            failures++; $display("FAIL rd_stable got=%b/%h exp=1/a5", bus.mem_read_ready[1], bus.mem_read_data[1]);
        end
        release_all(4'b0010);
        checks++; if (bus.mem_read_ready[1] !== 1'b0 || bus.mem_read_data[1] !== 8'hA5) begin
            failures++; $display("FAIL rd_release got=%b/%h exp=0/a5", bus.mem_read_ready[1], bus.mem_read_data[1]);
        end
    endtask

    task automatic test_write_collision();
        int lat;
        drive(0, 1'b0, 1'b1, 8'h20, 8'h11);
        drive(2, 1'b0, 1'b1, 8'h20, 8'h22);
        wait_ready(4'b0101, lat);
        checks++; if ((bus.mem_write_ready & 4'b0101) !== 4'b0101) begin failures++; $display("FAIL coll_acks got=%b exp=0101", bus.mem_write_ready); end
        release_all(4'b0101);
        model[8'h20] = 8'h11;
        drive(3, 1'b1, 1'b0, 8'h20, '0);
        wait_ready(4'b1000, lat);
        checks++; if (bus.mem_read_data[3] !== 8'h11) begin failures++; $display("FAIL coll_winner got=%h exp=11", bus.mem_read_data[3]); end
        release_all(4'b1000);
    endtask

    task automatic test_read_write_same_edge();
        int lat;
        drive(0, 1'b0, 1'b1, 8'h30, 8'h00);
        wait_ready(4'b0001, lat);
        release_all(4'b0001);
        drive(0, 1'b0, 1'b1, 8'h30, 8'h5A);
        drive(1, 1'b1, 1'b0, 8'h30, '0);
        wait_ready(4'b0011, lat);
        checks++; if (bus.mem_write_ready[0] !== 1'b1 || bus.mem_read_ready[1] !== 1'b1) begin
            failures++; $display("FAIL rw_acks got=%b/%b exp=1/1", bus.mem_write_ready[0], bus.mem_read_ready[1]);
        end
        checks++; if (bus.mem_read_data[1] !== 8'h00) begin failures++; $display("FAIL rw_old got=%h exp=00", bus.mem_read_data[1]); end
        release_all(4'b0011);
        model[8'h30] = 8'h5A;
        drive(2, 1'b1, 1'b0, 8'h30, '0);
        wait_ready(4'b0100, lat);
        checks++; if (bus.mem_read_data[2] !== 8'h5A) begin failures++; $display("FAIL rw_new got=%h exp=5a", bus.mem_read_data[2]); end
        release_all(4'b0100);
    endtask

    task automatic test_priority();
        int lat;
        logic [DB-1:0] d = DB'($urandom);
        logic [DB-1:0] old = model[8'h50];
        drive(3, 1'b1, 1'b1, 8'h50, d);
        wait_ready(4'b1000, lat);
        checks++; if (bus.mem_read_ready[3] !== 1'b1 || bus.mem_write_ready[3] !== 1'b0) begin
            failures++; $display("FAIL prio_first got=r%b/w%b exp=r1/w0", bus.mem_read_ready[3], bus.mem_write_ready[3]);
        end
        checks++; if (bus.mem_read_data[3] !== old) begin failures++; $display("FAIL prio_rdata got=%h exp=%h", bus.mem_read_data[3], old); end
        bus.mem_read_valid[3] = 1'b0;
        wait_ready(4'b1000, lat);
        checks++; if (lat !== LAT + 1 || bus.mem_write_ready[3] !== 1'b1) begin
            failures++; $display("FAIL prio_write got=lat%0d/w%b exp=lat%0d/w1", lat, bus.mem_write_ready[3], LAT + 1);
        end
        release_all(4'b1000);
        model[8'h50] = d;
        drive(3, 1'b1, 1'b0, 8'h50, '0);
        wait_ready(4'b1000, lat);
        checks++; if (bus.mem_read_data[3] !== d) begin failures++; $display("FAIL prio_commit got=%h exp=%h", bus.mem_read_data[3], d); end
        release_all(4'b1000);
    endtask

    task automatic test_reset_mid();
        int lat;
        drive(0, 1'b0, 1'b1, 8'h40, 8'h3C);
        wait_ready(4'b0001, lat);
        release_all(4'b0001);
        model[8'h40] = 8'h3C;
        drive(0, 1'b0, 1'b1, 8'h40, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if ((bus.mem_read_ready | bus.mem_write_ready) !== '0) begin
            failures++; $display("FAIL rst_mid_ready got=%h/%h exp=0/0", bus.mem_read_ready, bus.mem_write_ready);
        end
        repeat (4) @(negedge clk);
        checks++; if (bus.mem_write_ready !== '0) begin failures++; $display("FAIL rst_mid_late got=%h exp=0", bus.mem_write_ready); end
        drive(0, 1'b1, 1'b0, 8'h40, '0);
        wait_ready(4'b0001, lat);
        checks++; if (bus.mem_read_data[0] !== 8'h3C) begin failures++; $display("FAIL rst_mid_data got=%h exp=3c", bus.mem_read_data[0]); end
        release_all(4'b0001);
    endtask

    task automatic test_valid_drop();
        int highs = 0;
        logic [DB-1:0] seen = '0;
        logic [AB-1:0] a = AB'($urandom);
        drive(2, 1'b1, 1'b0, a, '0);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, '0, '0);
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_read_ready[2]) begin highs++; seen = bus.mem_read_data[2]; end
        end
        checks++; if (highs !== 1) begin failures++; $display("FAIL drop_pulse got=%0d exp=1", highs); end
        checks++; if (seen !== model[a]) begin failures++; $display("FAIL drop_data got=%h exp=%h", seen, model[a]); end
    endtask

    task automatic test_random_single();
        int lat;
        int ch;
        logic is_rd;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        for (int i = 0; i < 40; i++) begin
            ch = $urandom_range(0, NC - 1);
            is_rd = 1'($urandom);
            a = AB'($urandom);
            d = DB'($urandom);
            drive(ch, is_rd, !is_rd, a, d);
            wait_ready(NC'(1) << ch, lat);
            checks++; if (lat !== LAT) begin failures++; $display("FAIL rs_latency i=%0d got=%0d exp=%0d", i, lat, LAT); end
            if (is_rd) begin
                checks++; if (bus.mem_read_data[ch] !== model[a]) begin
                    failures++; $display("FAIL rs_rdata i=%0d ch=%0d got=%h exp=%h", i, ch, bus.mem_read_data[ch], model[a]);
                end
            end else begin
                model[a] = d;
            end
            release_all(NC'(1) << ch);
        end
    endtask

    task automatic test_random_concurrent();
        int lat;
        logic [NC-1:0] rmask;
        logic [AB-1:0] a [NC];
        logic [DB-1:0] d [NC];
        for (int r = 0; r < 30; r++) begin
            for (int ch = 0; ch < NC; ch++) begin
                rmask[ch] = 1'($urandom);
                a[ch] = AB'(8'h80 + $urandom_range(0, 1));
                d[ch] = DB'($urandom);
                drive(ch, rmask[ch], !rmask[ch], a[ch], d[ch]);
            end
            wait_ready('1, lat);
            checks++; if (lat !== LAT || bus.mem_read_ready !== rmask || bus.mem_write_ready !== ~rmask) begin
                failures++; $display("FAIL rc_acks r=%0d got=lat%0d r%b w%b exp=lat%0d r%b w%b", r, lat,
                                     bus.mem_read_ready, bus.mem_write_ready, LAT, rmask, ~rmask);
            end
            for (int ch = 0; ch < NC; ch++) begin
                if (rmask[ch]) begin
                    checks++; if (bus.mem_read_data[ch] !== model[a[ch]]) begin
                        failures++; $display("FAIL rc_rdata r=%0d ch=%0d got=%h exp=%h", r, ch, bus.mem_read_data[ch], model[a[ch]]);
                    end
                end
            end
            for (int ch = NC - 1; ch >= 0; ch--) if (!rmask[ch]) model[a[ch]] = d[ch];
            release_all('1);
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_write_basic();
        test_read_basic();
        test_write_collision();
        test_read_write_same_edge();
        test_priority();
        test_reset_mid();
        test_valid_drop();
        test_random_single();
        test_random_concurrent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
